// File: rtl/dpram_req_arbiter_pkg.sv
// Shared widths, deferred-entry layout and routing enums for the dual-port RAM request arbiter.
package dpram_req_arbiter_pkg;

  localparam int unsigned DPRAM_ADDR_W = 11;
  localparam int unsigned DPRAM_DATA_W = 8;
  localparam int unsigned DPRAM_DEPTH  = 4;

  typedef struct packed {
    logic [DPRAM_ADDR_W-1:0] addr;
    logic [DPRAM_DATA_W-1:0] data;
  } defer_entry_t;

  typedef enum logic [1:0] {
    ROUTE_NONE,
    ROUTE_DIRECT,
    ROUTE_DEFER
  } route_e;

  typedef enum logic [1:0] {
    DRAIN_NONE,
    DRAIN_B,
    DRAIN_A
  } drain_e;

endpackage

// File: rtl/dpram_req_arbiter_defer_fifo.sv
// Deferred-write FIFO: two push ports (push0 enqueued first), one pop port,
// per-entry address/valid view for the arbiter's hit compare.
module dpram_defer_fifo
  import dpram_req_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH  = DPRAM_DEPTH,
  parameter int unsigned ADDR_W = DPRAM_ADDR_W,
  parameter int unsigned DATA_W = DPRAM_DATA_W
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic                           push0_i,
  input  logic [ADDR_W-1:0]              push0_addr_i,
  input  logic [DATA_W-1:0]              push0_data_i,
  input  logic                           push1_i,
  input  logic [ADDR_W-1:0]              push1_addr_i,
  input  logic [DATA_W-1:0]              push1_data_i,
  input  logic                           pop_i,
  output logic [ADDR_W-1:0]              head_addr_o,
  output logic [DATA_W-1:0]              head_data_o,
  output logic [$clog2(DEPTH):0]         count_o,
  output logic [DEPTH-1:0]               entry_valid_o,
  output logic [DEPTH-1:0][ADDR_W-1:0]   entry_addr_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [DEPTH-1:0][ADDR_W-1:0] addr_q;
  logic [DEPTH-1:0][DATA_W-1:0] data_q;
  logic [PW-1:0]                wptr_q, wptr_d, rptr_q, rptr_d, wptr1;
  logic [CW-1:0]                count_q, count_d;

  always_comb begin
    wptr1   = push0_i ? wptr_q + PW'(1) : wptr_q;
    wptr_d  = wptr_q + PW'(push0_i) + PW'(push1_i);
    rptr_d  = rptr_q + PW'(pop_i);
    count_d = count_q + CW'(push0_i) + CW'(push1_i) - CW'(pop_i);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      if (push0_i) begin
        addr_q[wptr_q] <= push0_addr_i;
        data_q[wptr_q] <= push0_data_i;
      end
      if (push1_i) begin
        addr_q[wptr1] <= push1_addr_i;
        data_q[wptr1] <= push1_data_i;
      end
    end
  end

  // An entry is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    entry_valid_o = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      entry_valid_o[i] = {1'b0, PW'(i) - rptr_q} < count_q;
    end
  end

  assign head_addr_o  = addr_q[rptr_q];
  assign head_data_o  = data_q[rptr_q];
  assign count_o      = count_q;
  assign entry_addr_o = addr_q;

endmodule

// File: rtl/dpram_req_arbiter.sv
// Two-agent request arbiter in front of a dual-port RAM; same-address write
// collisions and writes to pending addresses are deferred through a small FIFO.
module dpram_req_arbiter
  import dpram_req_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = DPRAM_ADDR_W,
  parameter int unsigned DATA_W = DPRAM_DATA_W,
  parameter int unsigned DEPTH  = DPRAM_DEPTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid_a,
  input  logic                    req_valid_b,
  output logic                    req_ready_a,
  output logic                    req_ready_b,
  input  logic                    req_we_a,
  input  logic                    req_we_b,
  input  logic [ADDR_W-1:0]       req_addr_a,
  input  logic [ADDR_W-1:0]       req_addr_b,
  input  logic [DATA_W-1:0]       req_wdata_a,
  input  logic [DATA_W-1:0]       req_wdata_b,
  output logic                    ram_wr_en_a,
  output logic                    ram_wr_en_b,
  output logic                    ram_rd_en_a,
  output logic                    ram_rd_en_b,
  output logic [ADDR_W-1:0]       ram_addr_a,
  output logic [ADDR_W-1:0]       ram_addr_b,
  output logic [DATA_W-1:0]       ram_data_a,
  output logic [DATA_W-1:0]       ram_data_b,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output logic [15:0]             conflict_cnt
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] SPACE_MAX = CW'(DEPTH - 2);

  logic [CW-1:0]              fifo_cnt, eff_cnt;
  logic [DEPTH-1:0]           fifo_valid, eff_valid;
  logic [DEPTH-1:0][ADDR_W-1:0] fifo_addr;
  logic [ADDR_W-1:0]          head_addr;
  logic [DATA_W-1:0]          head_data;

  logic   hit_a, hit_b, space_ok;
  logic   acc_a, acc_b, push_a, push_b, collision, pop;
  route_e route_a, route_b;
  drain_e drain;

  logic              wr_a_q, wr_a_d, rd_a_q, rd_a_d, wr_b_q, wr_b_d, rd_b_q, rd_b_d;
  logic [ADDR_W-1:0] addr_a_q, addr_a_d, addr_b_q, addr_b_d;
  logic [DATA_W-1:0] data_a_q, data_a_d, data_b_q, data_b_d;
  logic [15:0]       conflict_q, conflict_d;

  // During reset the FIFO is treated as empty for the ready/hit decision.
  always_comb begin
    eff_cnt   = reset ? '0 : fifo_cnt;
    eff_valid = reset ? '0 : fifo_valid;
    hit_a     = 1'b0;
    hit_b     = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (eff_valid[i] && (fifo_addr[i] == req_addr_a)) hit_a = 1'b1;
      if (eff_valid[i] && (fifo_addr[i] == req_addr_b)) hit_b = 1'b1;
    end
    space_ok    = eff_cnt <= SPACE_MAX;
    req_ready_a = space_ok && !(!req_we_a && hit_a);
    acc_a       = req_valid_a && req_ready_a;
    push_a      = acc_a && req_we_a && hit_a;
    if (push_a && (req_addr_a == req_addr_b)) hit_b = 1'b1;
    req_ready_b = space_ok && !(!req_we_b && hit_b);
    acc_b       = req_valid_b && req_ready_b;
    collision   = acc_a && acc_b && req_we_a && req_we_b &&
                  (req_addr_a == req_addr_b) && !hit_a && !hit_b;
    push_b      = acc_b && req_we_b && (hit_b || collision);

    route_a = ROUTE_NONE;
    if (acc_a) route_a = push_a ? ROUTE_DEFER : ROUTE_DIRECT;
    route_b = ROUTE_NONE;
    if (acc_b) route_b = push_b ? ROUTE_DEFER : ROUTE_DIRECT;

    drain = DRAIN_NONE;
    if (eff_cnt != '0) begin
      if (route_b != ROUTE_DIRECT)      drain = DRAIN_B;
      else if (route_a != ROUTE_DIRECT) drain = DRAIN_A;
    end
    pop = (drain != DRAIN_NONE) && !reset;
  end

  dpram_defer_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk_i         (clk),
    .reset_i       (reset),
    .push0_i       (push_a && !reset),
    .push0_addr_i  (req_addr_a),
    .push0_data_i  (req_wdata_a),
    .push1_i       (push_b && !reset),
    .push1_addr_i  (req_addr_b),
    .push1_data_i  (req_wdata_b),
    .pop_i         (pop),
    .head_addr_o   (head_addr),
    .head_data_o   (head_data),
    .count_o       (fifo_cnt),
    .entry_valid_o (fifo_valid),
    .entry_addr_o  (fifo_addr)
  );

  always_comb begin
    wr_a_d   = 1'b0;
    rd_a_d   = 1'b0;
    addr_a_d = addr_a_q;
    data_a_d = data_a_q;
    wr_b_d   = 1'b0;
    rd_b_d   = 1'b0;
    addr_b_d = addr_b_q;
    data_b_d = data_b_q;

    if (route_a == ROUTE_DIRECT) begin
      wr_a_d   = req_we_a;
      rd_a_d   = !req_we_a;
      addr_a_d = req_addr_a;
      if (req_we_a) data_a_d = req_wdata_a;
    end else if (drain == DRAIN_A) begin
      wr_a_d   = 1'b1;
      addr_a_d = head_addr;
      data_a_d = head_data;
    end

    if (route_b == ROUTE_DIRECT) begin
      wr_b_d   = req_we_b;
      rd_b_d   = !req_we_b;
      addr_b_d = req_addr_b;
      if (req_we_b) data_b_d = req_wdata_b;
    end else if (drain == DRAIN_B) begin
      wr_b_d   = 1'b1;
      addr_b_d = head_addr;
      data_b_d = head_data;
    end

    conflict_d = conflict_q;
    if (collision && (conflict_q != '1)) conflict_d = conflict_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_a_q     <= 1'b0;
      rd_a_q     <= 1'b0;
      addr_a_q   <= '0;
      data_a_q   <= '0;
      wr_b_q     <= 1'b0;
      rd_b_q     <= 1'b0;
      addr_b_q   <= '0;
      data_b_q   <= '0;
      conflict_q <= '0;
    end else begin
      wr_a_q     <= wr_a_d;
      rd_a_q     <= rd_a_d;
      addr_a_q   <= addr_a_d;
      data_a_q   <= data_a_d;
      wr_b_q     <= wr_b_d;
      rd_b_q     <= rd_b_d;
      addr_b_q   <= addr_b_d;
      data_b_q   <= data_b_d;
      conflict_q <= conflict_d;
    end
  end

  assign ram_wr_en_a  = wr_a_q;
  assign ram_rd_en_a  = rd_a_q;
  assign ram_addr_a   = addr_a_q;
  assign ram_data_a   = data_a_q;
  assign ram_wr_en_b  = wr_b_q;
  assign ram_rd_en_b  = rd_b_q;
  assign ram_addr_b   = addr_b_q;
  assign ram_data_b   = data_b_q;
  assign fifo_count   = fifo_cnt;
  assign conflict_cnt = conflict_q;

endmodule

// File: tb/tb_dpram_req_arbiter.sv
// Bench for dpram_req_arbiter: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_dpram_req_arbiter;
  import dpram_req_arbiter_pkg::*;

  localparam int AW    = 11;
  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          va, vb, wa, wb;
  logic [AW-1:0] aa, ab;
  logic [DW-1:0] da, db;
  logic          req_ready_a, req_ready_b;
  logic          ram_wr_en_a, ram_wr_en_b, ram_rd_en_a, ram_rd_en_b;
  logic [AW-1:0] ram_addr_a, ram_addr_b;
  logic [DW-1:0] ram_data_a, ram_data_b;
  logic [2:0]    fifo_count;
  logic [15:0]   conflict_cnt;

  dpram_req_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid_a  (va),
    .req_valid_b  (vb),
    .req_ready_a  (req_ready_a),
    .req_ready_b  (req_ready_b),
    .req_we_a     (wa),
    .req_we_b     (wb),
    .req_addr_a   (aa),
    .req_addr_b   (ab),
    .req_wdata_a  (da),
    .req_wdata_b  (db),
    .ram_wr_en_a  (ram_wr_en_a),
    .ram_wr_en_b  (ram_wr_en_b),
    .ram_rd_en_a  (ram_rd_en_a),
    .ram_rd_en_b  (ram_rd_en_b),
    .ram_addr_a   (ram_addr_a),
    .ram_addr_b   (ram_addr_b),
    .ram_data_a   (ram_data_a),
    .ram_data_b   (ram_data_b),
    .fifo_count   (fifo_count),
    .conflict_cnt (conflict_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  defer_entry_t  q[$];
  logic          ewr_a, erd_a, ewr_b, erd_b;
  logic [AW-1:0] eaddr_a, eaddr_b;
  logic [DW-1:0] edata_a, edata_b;
  logic [15:0]   econf;
  logic [DW-1:0] dut_ram [0:2047];
  logic          srdy_a, srdy_b;
  int            max_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit q_has(input logic [AW-1:0] a);
    foreach (q[i]) if (q[i].addr == a) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drive(input logic iva, input logic iwa, input logic [AW-1:0] iaa, input logic [DW-1:0] ida,
                       input logic ivb, input logic iwb, input logic [AW-1:0] iab, input logic [DW-1:0] idb);
    va = iva; wa = iwa; aa = iaa; da = ida;
    vb = ivb; wb = iwb; ab = iab; db = idb;
  endtask

  // One clock: check ready against the model, advance the model, check the registered outputs.
  task automatic step();
    bit hitA, hitB, rdyA, rdyB, accA, accB, pushA, pushB, coll, dirA, dirB;
    int cnt;
    defer_entry_t e;
    #1;
    cnt   = reset ? 0 : q.size();
    hitA  = !reset && q_has(aa);
    rdyA  = (cnt <= DEPTH - 2) && !(!wa && hitA);
    accA  = va && rdyA;
    pushA = accA && wa && hitA;
    hitB  = (!reset && q_has(ab)) || (pushA && aa == ab);
    rdyB  = (cnt <= DEPTH - 2) && !(!wb && hitB);
    accB  = vb && rdyB;
    coll  = accA && accB && wa && wb && (aa == ab) && !hitA && !hitB;
    pushB = accB && wb && (hitB || coll);
    dirA  = accA && !pushA;
    dirB  = accB && !pushB;
    srdy_a = req_ready_a;
    srdy_b = req_ready_b;
    chk("ready_a", req_ready_a, rdyA);
    chk("ready_b", req_ready_b, rdyB);

    if (reset) begin
      q.delete();
      ewr_a = 0; erd_a = 0; eaddr_a = '0; edata_a = '0;
      ewr_b = 0; erd_b = 0; eaddr_b = '0; edata_b = '0;
      econf = '0;
    end else begin
      ewr_a = 0; erd_a = 0; ewr_b = 0; erd_b = 0;
      if (dirA) begin ewr_a = wa; erd_a = !wa; eaddr_a = aa; if (wa) edata_a = da; end
      if (dirB) begin ewr_b = wb; erd_b = !wb; eaddr_b = ab; if (wb) edata_b = db; end
      if (cnt > 0 && (!dirB || !dirA)) begin
        e = q.pop_front();
        if (!dirB) begin ewr_b = 1; eaddr_b = e.addr; edata_b = e.data; end
        else       begin ewr_a = 1; eaddr_a = e.addr; edata_a = e.data; end
      end
      if (pushA) begin e.addr = aa; e.data = da; q.push_back(e); end
      if (pushB) begin e.addr = ab; e.data = db; q.push_back(e); end
      if (coll && econf != 16'hFFFF) econf = econf + 16'd1;
    end

    @(posedge clk);
    #1;
    chk("wr_en_a", ram_wr_en_a, ewr_a);
    chk("rd_en_a", ram_rd_en_a, erd_a);
    chk("addr_a",  ram_addr_a,  eaddr_a);
    if (!erd_a) chk("data_a", ram_data_a, edata_a);
    chk("wr_en_b", ram_wr_en_b, ewr_b);
    chk("rd_en_b", ram_rd_en_b, erd_b);
    chk("addr_b",  ram_addr_b,  eaddr_b);
    if (!erd_b) chk("data_b", ram_data_b, edata_b);
    chk("fifo_count", fifo_count, q.size());
    chk("conflict_cnt", conflict_cnt, econf);
    if (ram_wr_en_a) dut_ram[ram_addr_a] = ram_data_a;
    if (ram_wr_en_b) dut_ram[ram_addr_b] = ram_data_b;
    if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ia, ib, guard, nwr;
    bit saw_stall;
    for (int i = 0; i < 2048; i++) dut_ram[i] = '0;
    reset = 1'b1;
    drive(0, 0, '0, '0, 0, 0, '0, '0);
    max_cnt = 0;
    @(negedge clk);
    step();
    step();
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_conflict", conflict_cnt, 0);
    chk("rst_wr_en_a", ram_wr_en_a, 0);
    chk("rst_addr_b", ram_addr_b, 0);
    reset = 1'b0;

    // Independent writes on both ports
    drive(1, 1, 11'h010, 8'h11, 1, 1, 11'h020, 8'h22);
    step();
    chk("r36_wr_a", ram_wr_en_a, 1);
    chk("r36_addr_a", ram_addr_a, 11'h010);
    chk("r36_data_a", ram_data_a, 8'h11);
    chk("r36_wr_b", ram_wr_en_b, 1);
    chk("r36_addr_b", ram_addr_b, 11'h020);
    chk("r36_data_b", ram_data_b, 8'h22);
    chk("r36_count", fifo_count, 0);
    drive(0, 0, '0, '0, 0, 0, '0, '0);
    step();

    // Collision, then B read of the deferred address
    drive(1, 1, 11'h055, 8'hAA, 1, 1, 11'h055, 8'hBB);
    step();
    chk("r37_wr_a", ram_wr_en_a, 1);
    chk("r37_data_a", ram_data_a, 8'hAA);
    chk("r37_wr_b", ram_wr_en_b, 0);
    chk("r37_count", fifo_count, 1);
    drive(0, 0, '0, '0, 1, 0, 11'h055, '0);
    step();
    chk("r38_stall_b", srdy_b, 0);
    chk("r37_def_wr_b", ram_wr_en_b, 1);
    chk("r37_def_addr_b", ram_addr_b, 11'h055);
    chk("r37_def_data_b", ram_data_b, 8'hBB);
    chk("r37_conflict", conflict_cnt, 1);
    step();
    chk("r38_ready_b", srdy_b, 1);
    chk("r38_rd_b", ram_rd_en_b, 1);
    chk("r38_rd_addr_b", ram_addr_b, 11'h055);
    drive(0, 0, '0, '0, 0, 0, '0, '0);
    step();

    // Repeated same-address collisions with agents holding their requests
    ia = 0; ib = 0; guard = 0; saw_stall = 0; max_cnt = 0;
    while ((ia < 4 || ib < 4) && guard < 30) begin
      drive(ia < 4, 1, 11'h077, DW'(8'hA0 + ia), ib < 4, 1, 11'h077, DW'(8'hB0 + ib));
      step();
      if (va && vb && !srdy_a && !srdy_b) saw_stall = 1;
      if (ia < 4 && srdy_a) ia++;
      if (ib < 4 && srdy_b) ib++;
      guard++;
    end
    chk("r39_accepted", ia + ib, 8);
    chk("r39_max_count", max_cnt, DEPTH - 1);
    chk("r39_stall", saw_stall, 1);
    drive(0, 0, '0, '0, 0, 0, '0, '0);
    guard = 0;
    while (fifo_count != 0 && guard < 20) begin
      step();
      guard++;
    end
    chk("r39_drained", fifo_count, 0);
    chk("r39_ram_final", dut_ram[11'h077], 8'hB3);

    // Reset with pending deferred writes
    drive(1, 1, 11'h0AA, 8'h01, 1, 1, 11'h0AA, 8'h02);
    step();
    drive(1, 1, 11'h0AA, 8'h03, 1, 1, 11'h0AA, 8'h04);
    step();
    chk("r40_pre_count", fifo_count, 2);
    reset = 1'b1;
    drive(0, 0, '0, '0, 1, 0, 11'h0AA, '0);
    step();
    chk("r40_rst_ready_b", srdy_b, 1);
    chk("r40_count", fifo_count, 0);
    chk("r40_wr_a", ram_wr_en_a, 0);
    chk("r40_wr_b", ram_wr_en_b, 0);
    chk("r40_rd_b", ram_rd_en_b, 0);
    chk("r40_conflict", conflict_cnt, 0);
    reset = 1'b0;
    drive(0, 0, '0, '0, 0, 0, '0, '0);
    nwr = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      nwr += int'(ram_wr_en_a) + int'(ram_wr_en_b);
    end
    chk("r40_no_deferred", nwr, 0);

    // Randomized traffic over a small address window
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 199) == 0);
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 2) != 0, AW'(11'h100 + $urandom_range(0, 3)), DW'($urandom),
            $urandom_range(0, 9) < 7, $urandom_range(0, 2) != 0, AW'(11'h100 + $urandom_range(0, 3)), DW'($urandom));
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dpram_req_arbiter.md
DPRAM_REQ_ARBITER -- requirements
Module: dpram_req_arbiter

Interface
REQ-001 Parameter ADDR_W, default 11: request and RAM address width.
REQ-002 Parameter DATA_W, default 8: write data width.
REQ-003 Parameter DEPTH, default 4: deferred-write FIFO entries; power of two, at least 2.
REQ-004 clk  in  1  single clock; all logic on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 req_valid_a / req_valid_b  in  1  agent request present.
REQ-007 req_ready_a / req_ready_b  out  1  request accepted this cycle when high together with valid; combinational.
REQ-008 req_we_a / req_we_b  in  1  1 = write, 0 = read.
REQ-009 req_addr_a / req_addr_b  in  ADDR_W  request address.
REQ-010 req_wdata_a / req_wdata_b  in  DATA_W  write data.
REQ-011 ram_wr_en_a / ram_wr_en_b  out  1  registered RAM write enable.
REQ-012 ram_rd_en_a / ram_rd_en_b  out  1  registered RAM read enable.
REQ-013 ram_addr_a / ram_addr_b  out  ADDR_W  registered RAM address.
REQ-014 ram_data_a / ram_data_b  out  DATA_W  registered RAM write data.
REQ-015 fifo_count  out  clog2(DEPTH)+1  current deferred-write occupancy.
REQ-016 conflict_cnt  out  16  saturating count of same-address write collisions.

Function
REQ-017 Accepted request = valid && ready on that port; its RAM command appears on the ram_* outputs exactly 1 cycle later.
REQ-018 Read data is not handled; it returns from the RAM combinationally one cycle after acceptance.
REQ-019 Hit = request address equals the address of any valid FIFO entry, or of a port A write being pushed in the same cycle (checked for port B only).
REQ-020 req_ready_x = (fifo_count <= DEPTH-2) && !(read request && hit); ready never depends on the other port's ready.
REQ-021 Read without hit: issued directly on its own RAM port (rd_en=1, addr).
REQ-022 Write without hit and without collision: issued directly on its own RAM port (wr_en=1, addr, data).
REQ-023 Collision = both accepted writes, equal address, neither hits: A issued directly, B pushed into FIFO, conflict_cnt += 1 (saturate at 16'hFFFF).
REQ-024 Write with hit: pushed into FIFO (no direct issue), preserving per-address order.
REQ-025 Two pushes in one cycle: the A entry is enqueued before the B entry.
REQ-026 Drain: at most one pop per cycle; the head is issued on RAM port B if port B has no direct command this cycle, else on port A if idle, else not popped.
REQ-027 A pop uses the head as it was at the start of the cycle; entries pushed this cycle are not poppable until the next cycle.
REQ-028 Push and pop in the same cycle update fifo_count by pushes minus pops; the pointers wrap modulo DEPTH.
REQ-029 An idle RAM port has wr_en=0, rd_en=0; addr and data hold their previous values.
REQ-030 No RAM port ever carries two commands in one cycle; the FIFO never overflows or underflows.

Reset
REQ-031 When reset is high at an edge: FIFO emptied, fifo_count=0, conflict_cnt=0, all ram_wr_en/ram_rd_en=0, ram_addr/ram_data=0.
REQ-032 Reset mid-operation discards pending deferred writes; they are never issued.
REQ-033 During reset the req_ready outputs follow REQ-020 with an empty FIFO; requests accepted in the reset cycle are dropped.

Structure
REQ-034 The shared package holds ADDR_W/DATA_W defaults and the packed deferred-entry typedef {addr, data}.
REQ-035 One sub-module, dpram_defer_fifo: synchronous FIFO with 2 push ports and 1 pop port, exposing its entries for the address-hit compare.

Verification
REQ-036 A write 0x010=0x11 and B write 0x020=0x22 in the same cycle -> next cycle both ports wr_en=1 with their own addr/data; fifo_count=0.
REQ-037 A and B write 0x055 (0xAA, 0xBB) in the same cycle -> cycle+1: port A writes 0xAA and fifo_count=1; cycle+2: port B writes 0xBB from FIFO; conflict_cnt=1.
REQ-038 Collision as in REQ-037, then B reads 0x055 the next cycle -> req_ready_b=0 until the deferred write issues; the read is issued in the following cycle.
REQ-039 Four consecutive same-address collisions with both ports kept busy -> fifo_count reaches DEPTH-1, then req_ready_a and req_ready_b both drop; after the agents idle, the FIFO drains in order; RAM final value is the last B data.
REQ-040 Reset asserted with fifo_count=2 -> next cycle fifo_count=0, all enables 0, conflict_cnt=0; no deferred write appears afterwards.
